// File: rtl/reg_axil_cpu_master.sv
// AXI4-Lite slave to simple CPU register bus bridge; one register access at a time.
// Optional macro REG_AXIL_ADDR_CHECK_EN: out-of-range addresses return DECERR without a CPU strobe.
module reg_axil_cpu_master #(
   parameter int CPU_ADDR_WIDTH = 12,
   parameter int CPU_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int RD_LATENCY     = 2,
   parameter int REG_NUM        = 10
) (
   input  logic                        clks,
   input  logic                        reset,
   input  logic                        s_awvalid,
   output logic                        s_awready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                        s_wvalid,
   output logic                        s_wready,
   input  logic [CPU_DATA_WIDTH-1:0]   s_wdata,
   input  logic [CPU_DATA_WIDTH/8-1:0] s_wstrb,
   output logic                        s_bvalid,
   input  logic                        s_bready,
   output logic [1:0]                  s_bresp,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   output logic [CPU_DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]                  s_rresp,
   output logic                        cpu_wr,
   output logic [CPU_ADDR_WIDTH-1:0]   cpu_wr_addr,
   output logic [CPU_DATA_WIDTH-1:0]   cpu_data_in,
   output logic                        cpu_rd,
   input  logic [CPU_DATA_WIDTH-1:0]   cpu_data_out
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD      = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_RD_RESP = 3'd5;

   localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY);

   logic [2:0] state;
   logic       prio_wr;
   logic [3:0] rd_cnt;
   logic       rd_err;
   logic       wr_req;
   logic       rd_req;
   logic       grant_wr;
   logic       grant_rd;
   logic       idle;
   logic       strb_full;
   logic       wr_addr_ok;
   logic       ar_addr_ok;

   function automatic logic [1:0] wr_resp_code(input logic addr_ok, input logic full);
      if (!addr_ok)
         return 2'b11;
      else if (!full)
         return 2'b10;
      else
         return 2'b00;
   endfunction

`ifdef REG_AXIL_ADDR_CHECK_EN
   function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
      return ((a >> (CPU_ADDR_WIDTH + 2)) == '0) &&
             (32'(a[CPU_ADDR_WIDTH+1:2]) < 32'(REG_NUM));
   endfunction

   assign wr_addr_ok = addr_in_range(s_awaddr);
   assign ar_addr_ok = addr_in_range(s_araddr);
`else
   logic unused_cfg;

   assign wr_addr_ok = 1'b1;
   assign ar_addr_ok = 1'b1;
   assign unused_cfg = ^{s_awaddr, s_araddr, (REG_NUM > 0)};
`endif

   // A write needs both AW and W present; ties go to the side named by prio_wr.
   assign idle      = (state == S_IDLE) && !reset;
   assign wr_req    = s_awvalid && s_wvalid;
   assign rd_req    = s_arvalid;
   assign grant_wr  = wr_req && (!rd_req || prio_wr);
   assign grant_rd  = rd_req && (!wr_req || !prio_wr);
   assign strb_full = &s_wstrb;

   assign s_awready = idle && grant_wr;
   assign s_wready  = idle && grant_wr;
   assign s_arready = idle && grant_rd;

   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         prio_wr     <= 1'b1;
         rd_cnt      <= '0;
         rd_err      <= 1'b0;
         cpu_wr      <= 1'b0;
         cpu_rd      <= 1'b0;
         cpu_wr_addr <= '0;
         cpu_data_in <= '0;
         s_bvalid    <= 1'b0;
         s_bresp     <= 2'b00;
         s_rvalid    <= 1'b0;
         s_rdata     <= '0;
         s_rresp     <= 2'b00;
      end else begin
         cpu_wr <= 1'b0;
         cpu_rd <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_wr) begin
                  cpu_wr_addr <= s_awaddr[CPU_ADDR_WIDTH+1:2];
                  cpu_data_in <= s_wdata;
                  cpu_wr      <= strb_full && wr_addr_ok;
                  s_bresp     <= wr_resp_code(wr_addr_ok, strb_full);
                  if (rd_req)
                     prio_wr <= ~prio_wr;
                  state <= S_WR;
               end else if (grant_rd) begin
                  cpu_wr_addr <= s_araddr[CPU_ADDR_WIDTH+1:2];
                  cpu_rd      <= ar_addr_ok;
                  rd_err      <= !ar_addr_ok;
                  if (wr_req)
                     prio_wr <= ~prio_wr;
                  state <= S_RD;
               end
            end
            S_WR: begin
               s_bvalid <= 1'b1;
               state    <= S_WR_RESP;
            end
            S_WR_RESP: begin
               if (s_bready) begin
                  s_bvalid <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            S_RD: begin
               rd_cnt <= RD_CNT_INIT;
               state  <= S_RD_WAIT;
            end
            // Sample on the cycle the counter runs out so rvalid rises RD_LATENCY after RD_WAIT entry.
            S_RD_WAIT: begin
               rd_cnt <= rd_cnt - 4'd1;
               if (rd_cnt == 4'd1) begin
                  s_rdata  <= rd_err ? '0 : cpu_data_out;
                  s_rresp  <= rd_err ? 2'b11 : 2'b00;
                  s_rvalid <= 1'b1;
                  state    <= S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               if (s_rready) begin
                  s_rvalid <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_axil_cpu_master.sv
// Directed bench for reg_axil_cpu_master; covers the REG_AXIL_ADDR_CHECK_EN build when defined.
module tb_reg_axil_cpu_master;

  logic        clks;
  logic        reset;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        cpu_wr;
  logic [11:0] cpu_wr_addr;
  logic [31:0] cpu_data_in;
  logic        cpu_rd;
  logic [31:0] cpu_data_out = 32'h0;
  logic [31:0] resp_val;

  int errors;
  int checks;

  reg_axil_cpu_master dut (
    .clks         (clks),
    .reset        (reset),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_awaddr     (s_awaddr),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_bresp      (s_bresp),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_araddr     (s_araddr),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .cpu_wr       (cpu_wr),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_rd       (cpu_rd),
    .cpu_data_out (cpu_data_out)
  );

  initial clks = 1'b0;
  always #5 clks = ~clks;

  // Register-block stand-in: registered read data one cycle after cpu_rd.
  always @(posedge clks) begin
    if (cpu_rd)
      cpu_data_out <= resp_val;
  end

  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    repeat (2) @(posedge clks);
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd});
    end
    checks++;
    if (cpu_wr_addr !== 12'h0 || cpu_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h expected 0/0", cpu_wr_addr, cpu_data_in);
    end
    checks++;
    if (s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp: got rdata=%h bresp=%b rresp=%b expected 0", s_rdata, s_bresp, s_rresp);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    s_awaddr = 32'h008; s_wdata = 32'h0000_0005; s_wstrb = 4'hF; s_bready = 1'b0;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready: got aw=%b w=%b expected 1/1", s_awready, s_wready);
    end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if (cpu_wr !== 1'b1 || cpu_wr_addr !== 12'h002 || cpu_data_in !== 32'h5) begin
      errors++;
      $display("FAIL wr_strobe: got wr=%b addr=%h data=%h expected 1/002/00000005",
               cpu_wr, cpu_wr_addr, cpu_data_in);
    end
    tick();
    checks++;
    if (cpu_wr !== 1'b0 || s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errors++;
      $display("FAIL wr_bresp: got wr=%b bvalid=%b bresp=%b expected 0/1/00", cpu_wr, s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_bdone: got bvalid=%b expected 0", s_bvalid);
    end
  endtask

  task automatic test_read();
    resp_val = 32'h1234_5678; s_araddr = 32'h010; s_rready = 1'b0;
    s_arvalid = 1'b1;
    #1;
    checks++;
    if (s_arready !== 1'b1) begin
      errors++;
      $display("FAIL rd_ready: got arready=%b expected 1", s_arready);
    end
    tick();
    s_arvalid = 1'b0;
    checks++;
    if (cpu_rd !== 1'b1 || cpu_wr_addr !== 12'h004) begin
      errors++;
      $display("FAIL rd_strobe: got rd=%b addr=%h expected 1/004", cpu_rd, cpu_wr_addr);
    end
    tick();
    checks++;
    if (cpu_rd !== 1'b0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t2: got rd=%b rvalid=%b expected 0/0", cpu_rd, s_rvalid);
    end
    tick();
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t3: got rvalid=%b expected 0", s_rvalid);
    end
    tick();
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h1234_5678 || s_rresp !== 2'b00) begin
      errors++;
      $display("FAIL rd_t4: got rvalid=%b rdata=%h rresp=%b expected 1/12345678/00",
               s_rvalid, s_rdata, s_rresp);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: got rvalid=%b expected 0", s_rvalid);
    end
  endtask

  task automatic test_arbitration();
    logic aw_pend, ar_pend, prev, concur, consec, bseen, rseen;
    int   first;
    s_bready = 1'b1; s_rready = 1'b1;
    s_wstrb = 4'hF; resp_val = 32'h0BAD_CAFE;
    for (int p = 0; p < 2; p++) begin
      s_awaddr = 32'h014; s_wdata = 32'h77 + 32'(p); s_araddr = 32'h018;
      aw_pend = 1'b1; ar_pend = 1'b1; prev = 1'b0; concur = 1'b0; consec = 1'b0;
      bseen = 1'b0; rseen = 1'b0; first = 0;
      for (int c = 0; c < 40 && !(bseen && rseen); c++) begin
        s_awvalid = aw_pend; s_wvalid = aw_pend; s_arvalid = ar_pend;
        #1;
        if (s_awready && s_arready) concur = 1'b1;
        if (first == 0 && s_awready) first = 1;
        else if (first == 0 && s_arready) first = 2;
        if (s_awready) aw_pend = 1'b0;
        if (s_arready) ar_pend = 1'b0;
        if (cpu_wr && cpu_rd) concur = 1'b1;
        if ((cpu_wr || cpu_rd) && prev) consec = 1'b1;
        prev = cpu_wr || cpu_rd;
        if (s_bvalid) bseen = 1'b1;
        if (s_rvalid) rseen = 1'b1;
        tick();
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      checks++;
      if (first !== ((p == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL arb_order%0d: got first=%0d expected %0d (1=write 2=read)",
                 p, first, (p == 0) ? 1 : 2);
      end
      checks++;
      if (concur !== 1'b0 || consec !== 1'b0) begin
        errors++;
        $display("FAIL arb_strobes%0d: got concurrent=%b consecutive=%b expected 0/0", p, concur, consec);
      end
      checks++;
      if (!(bseen && rseen)) begin
        errors++;
        $display("FAIL arb_done%0d: got b=%b r=%b expected 1/1 within budget", p, bseen, rseen);
      end
    end
    s_bready = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_backpressure();
    s_awaddr = 32'h008; s_wdata = 32'hA; s_wstrb = 4'hF; s_bready = 1'b0;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    resp_val = 32'h0000_00AA; s_araddr = 32'h010; s_arvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got bvalid=%b bresp=%b arready=%b expected 1/00/0",
                 c, s_bvalid, s_bresp, s_arready);
      end
      tick();
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || s_arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got bvalid=%b arready=%b expected 0/1", s_bvalid, s_arready);
    end
    tick();
    s_arvalid = 1'b0; s_rready = 1'b1;
    for (int c = 0; c < 10 && !s_rvalid; c++) tick();
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL bp_read: got rvalid=%b rdata=%h expected 1/000000aa", s_rvalid, s_rdata);
    end
    tick();
    s_rready = 1'b0;
  endtask

  task automatic test_partial_strobe();
    s_awaddr = 32'h00C; s_wdata = 32'h0000_DEAD; s_wstrb = 4'h3; s_bready = 1'b0;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL strb_ready: got awready=%b expected 1", s_awready);
    end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if (cpu_wr !== 1'b0) begin
      errors++;
      $display("FAIL strb_nowr: got cpu_wr=%b expected 0", cpu_wr);
    end
    tick();
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin
      errors++;
      $display("FAIL strb_bresp: got bvalid=%b bresp=%b expected 1/10", s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0; s_wstrb = 4'hF;
  endtask

  task automatic test_addr_check();
    resp_val = 32'hCAFE_F00D; s_araddr = 32'h040; s_rready = 1'b0;
    s_arvalid = 1'b1;
    #1;
    checks++;
    if (s_arready !== 1'b1) begin
      errors++;
      $display("FAIL ac_ready: got arready=%b expected 1", s_arready);
    end
    tick();
    s_arvalid = 1'b0;
`ifdef REG_AXIL_ADDR_CHECK_EN
    checks++;
    if (cpu_rd !== 1'b0) begin
      errors++;
      $display("FAIL ac_nord: got cpu_rd=%b expected 0", cpu_rd);
    end
`else
    checks++;
    if (cpu_rd !== 1'b1 || cpu_wr_addr !== 12'h010) begin
      errors++;
      $display("FAIL ac_fwd: got rd=%b addr=%h expected 1/010", cpu_rd, cpu_wr_addr);
    end
`endif
    repeat (3) tick();
`ifdef REG_AXIL_ADDR_CHECK_EN
    checks++;
    if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || s_rdata !== 32'h0) begin
      errors++;
      $display("FAIL ac_resp: got rvalid=%b rresp=%b rdata=%h expected 1/11/00000000",
               s_rvalid, s_rresp, s_rdata);
    end
`else
    checks++;
    if (s_rvalid !== 1'b1 || s_rresp !== 2'b00 || s_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL ac_resp: got rvalid=%b rresp=%b rdata=%h expected 1/00/cafef00d",
               s_rvalid, s_rresp, s_rdata);
    end
`endif
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic saw_rvalid;
    resp_val = 32'h0000_0055; s_araddr = 32'h010; s_rready = 1'b1;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    checks++;
    if (cpu_rd !== 1'b1) begin
      errors++;
      $display("FAIL mid_rd: got cpu_rd=%b expected 1", cpu_rd);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd} !== 7'b0 ||
        cpu_wr_addr !== 12'h0 || cpu_data_in !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got ctrl=%b addr=%h data=%h expected 0",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd},
               cpu_wr_addr, cpu_data_in);
    end
    checks++;
    if (s_rdata !== 32'h0 || s_rresp !== 2'b00 || s_bresp !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_resp: got rdata=%h rresp=%b bresp=%b expected 0",
               s_rdata, s_rresp, s_bresp);
    end
    repeat (2) tick();
    reset = 1'b0;
    saw_rvalid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_rvalid) saw_rvalid = 1'b1;
    end
    checks++;
    if (saw_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resp: got rvalid seen=%b expected 0", saw_rvalid);
    end
    s_rready = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = 4'hF;
    s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
    resp_val = '0;
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_backpressure();
    test_partial_strobe();
    test_addr_check();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_axil_cpu_master.md
Name: reg_axil_cpu_master

Overview:
- Bridges an AXI4-Lite slave port (host register path) onto the simple CPU register bus consumed by the user-logic register block: cpu_wr, cpu_wr_addr, cpu_data_in, cpu_rd, cpu_data_out.
- Acts as the single bus initiator and issues one register access at a time.
- Serialises reads and writes, holds the address stable across each access, and samples the registered read data after a fixed latency.

Parameters:
- CPU_ADDR_WIDTH, 12: word-address width on the CPU bus.
- CPU_DATA_WIDTH, 32: data width on both sides.
- AXI_ADDR_WIDTH, 32: AXI byte-address width.
- RD_LATENCY, 2: cycles from cpu_rd assertion to the cpu_data_out sample point. Range 1..15.
- REG_NUM, 10: number of implemented word registers. Used only by the optional feature.

Ports:
- clks  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_awvalid/s_awready  in/out  1  write-address handshake
- s_awaddr  in  AXI_ADDR_WIDTH  write byte address
- s_wvalid/s_wready  in/out  1  write-data handshake
- s_wdata  in  CPU_DATA_WIDTH  write data
- s_wstrb  in  CPU_DATA_WIDTH/8  byte strobes
- s_bvalid/s_bready  out/in  1  write-response handshake
- s_bresp  out  2  write response
- s_arvalid/s_arready  in/out  1  read-address handshake
- s_araddr  in  AXI_ADDR_WIDTH  read byte address
- s_rvalid/s_rready  out/in  1  read-response handshake
- s_rdata  out  CPU_DATA_WIDTH  read data
- s_rresp  out  2  read response
- cpu_wr  out  1  single-cycle write strobe
- cpu_wr_addr  out  CPU_ADDR_WIDTH  shared read/write word address
- cpu_data_in  out  CPU_DATA_WIDTH  write data to the register block
- cpu_rd  out  1  single-cycle read strobe
- cpu_data_out  in  CPU_DATA_WIDTH  registered read data from the register block

Behaviour:
- Clock clks. Reset is asynchronous and active-high, named reset.
- Reset values: all ready/valid outputs 0, cpu_wr 0, cpu_rd 0, cpu_wr_addr 0, cpu_data_in 0, s_rdata 0, s_bresp 0, s_rresp 0, FSM in IDLE, priority flag = write.
- Word address: cpu_wr_addr = addr[CPU_ADDR_WIDTH+1:2]. Address bits [1:0] and bits above CPU_ADDR_WIDTH+1 are ignored.
- FSM states: IDLE, WR, WR_RESP, RD, RD_WAIT, RD_RESP.
- IDLE, write request: a write is pending only when s_awvalid and s_wvalid are both high. s_awready and s_wready are asserted together, combinationally, in the same cycle (T). Address and data are latched. Next state is WR.
- IDLE, read request: when s_arvalid is high and the read is granted, s_arready is asserted. The address is latched. Next state is RD.
- Arbitration: a write and a read pending in the same IDLE cycle are granted by the priority flag, which then toggles. A lone request is granted without changing the flag.
- WR (cycle T+1): cpu_wr=1 for exactly one cycle with cpu_wr_addr and cpu_data_in valid. Next state is WR_RESP.
- Partial strobe: if s_wstrb is not all-ones, cpu_wr stays 0 and s_bresp=2'b10 (SLVERR). Otherwise s_bresp=2'b00.
- WR_RESP: s_bvalid=1 from T+2 and is held until s_bready. Next state is IDLE.
- RD (cycle T+1): cpu_rd=1 for exactly one cycle. A counter loads RD_LATENCY. Next state is RD_WAIT.
- RD_WAIT: counter decrements each cycle. When it reaches 0, cpu_data_out is sampled into s_rdata and s_rresp=2'b00. Next state is RD_RESP, so s_rvalid first rises at T+2+RD_LATENCY.
- RD_RESP: s_rvalid and s_rdata are held stable until s_rready. Next state is IDLE.
- cpu_wr_addr holds its last value between transactions. It never changes while cpu_wr, cpu_rd, RD_WAIT or a response is outstanding.
- cpu_wr and cpu_rd are never high in the same cycle and are never high in consecutive cycles.
- No ready output is asserted outside IDLE. Back-pressure on B or R stalls all new acceptance.
- Reset mid-transaction: immediate return to reset values. The aborted access produces no response. A CPU strobe already issued is not retracted.

Optional Feature:
- Macro REG_AXIL_ADDR_CHECK_EN.
- Defined: an address whose upper bits above CPU_ADDR_WIDTH+1 are nonzero, or whose word index is >= REG_NUM, issues no cpu_wr/cpu_rd and returns DECERR (2'b11). Reads also return s_rdata=0. Response timing is unchanged: write at T+2, read at T+2+RD_LATENCY.
- Undefined: all addresses are forwarded and the upper bits are ignored.

Test Plan:
- AW 0x008 + W 0x0000_0005, wstrb 0xF -> cpu_wr pulse at T+1 with cpu_wr_addr 0x002, cpu_data_in 5; bvalid at T+2 with bresp 00.
- AR 0x010, bench responder returns 0x1234_5678 one cycle after the address -> cpu_rd pulse at T+1 with addr 0x004; rvalid at T+4 with rdata 0x1234_5678, rresp 00.
- AW/W and AR valid in the same cycle, twice back-to-back -> first pair: write first, then read; second pair: read first; never concurrent strobes.
- bready held low for 10 cycles -> bvalid and bresp stable; arready stays 0 despite arvalid.
- wstrb 0x3 to 0x00C -> no cpu_wr; bresp 10. Reset asserted at the RD_WAIT cycle -> all outputs at reset values, no rvalid.
- With REG_AXIL_ADDR_CHECK_EN: AR 0x040 (index 16 >= 10) -> no cpu_rd; rresp 11 with rdata 0 at T+4.
